ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Sits directly downstream of the PS/2 scan-code receiver.
- Consumes its 10-bit code word {expand, break, scancode[7:0]} and its 1-cycle ready strobe.
- Tracks the make/break state of four game keys and produces per-key held levels and one-cycle press pulses.
- Queues press/release events in a small FIFO so the game FSM (flap, start, pause) can consume them at its own pace.

Parameters:
KEY0_CODE, 9'h029, {expand, scancode} of key 0 (Space = flap)
KEY1_CODE, 9'h175, {expand, scancode} of key 1 (extended Up arrow = flap)
KEY2_CODE, 9'h05A, {expand, scancode} of key 2 (Enter = start)
KEY3_CODE, 9'h076, {expand, scancode} of key 3 (Esc = pause)
FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous active-high reset
key_data  input  10  receiver code word: bit9 expand, bit8 break, bits7:0 scancode
key_ready  input  1  1-cycle strobe; key_data is valid while high
key_held  output  4  level per key; 1 = key currently down
key_press  output  4  1-cycle pulse per key on a fresh make
evt_valid  output  1  FIFO not empty
evt_data  output  3  head event: bit2 = 1 release / 0 press; bits1:0 = key index
evt_pop  input  1  consume head event; honoured only when evt_valid = 1
evt_ovf  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge):
  - key_held = 0, key_press = 0.
  - FIFO emptied: evt_valid = 0, evt_data = 0.
  - evt_ovf = 0.
  - Reset mid-operation discards all held state and queued events. No release events are generated for keys that were down.
- Matching:
  - Only on cycles with key_ready = 1.
  - Compare {key_data[9], key_data[7:0]} against each KEYn_CODE; key_data[8] selects make (0) or break (1).
  - Unmatched codes are ignored entirely.
  - If two parameters are equal, the lowest index wins.
- Per-key FSM, two states, UP and DOWN:
  - UP + make -> DOWN: key_press[n] = 1 for exactly one cycle; push press event {0, n}.
  - DOWN + make (typematic repeat) -> stay DOWN: no pulse, no event.
  - DOWN + break -> UP: push release event {1, n}.
  - UP + break (spurious) -> stay UP: no event.
  - key_held[n] = 1 exactly in DOWN.
- Latency:
  - key_ready at edge N: key_held, key_press and the FIFO write all take effect at edge N+1.
  - evt_valid rises the cycle after the write when the FIFO was empty; there is no bypass.
  - key_press is high for the single cycle following edge N+1.
- FIFO:
  - Synchronous, first-word-fall-through; evt_data always shows the head.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count register is one bit wider.
  - Pop when empty: ignored, pointers unchanged.
  - Push when full without a same-cycle pop: event dropped, evt_ovf set to 1; it stays set until rst.
  - Push and pop in the same cycle while full: both performed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push is stored; the pop is ignored.
- key_ready never asserts on consecutive cycles (the receiver guarantees this). The block must still handle back-to-back strobes correctly, at one event per cycle.

Optional Feature:
- KEY_REPEAT_EN defined:
  - DOWN + make (typematic) additionally asserts key_press[n] for one cycle and pushes press event {0, n}.
  - key_held is unchanged (stays 1).
  - Holding flap then produces repeated flaps at the keyboard repeat rate.
- KEY_REPEAT_EN undefined:
  - Repeats are suppressed exactly as described under Behaviour.

Test Plan:
- Reset release, then key_data = 10'h029 with key_ready -> next cycle key_held = 4'b0001, key_press = 4'b0001 for 1 cycle; evt_valid = 1 with evt_data = 3'b000 one cycle later.
- Repeat 10'h029 three times, then break 10'h129 -> key_press never re-fires; FIFO holds only {000, 100}; key_held[0] returns to 0.
- Extended Up 10'h275 then 10'h075 (non-extended, same scancode) -> only key 1 reacts to the first; the second is ignored; evt_data = 3'b001.
- Spurious break 10'h15A with no prior make -> no event, key_held = 0; unmatched code 10'h01C -> no change.
- Five press events with no pop (DEPTH 4) -> evt_ovf = 1, FIFO holds the first 4 in order. Pop+push simultaneously while full -> no additional overflow; the order is preserved across pointer wrap.
- Assert rst while key 2 is held with 2 events queued -> key_held = 0, evt_valid = 0, evt_ovf = 0 next cycle. With KEY_REPEAT_EN, a repeated 10'h05A produces a key_press[2] pulse per repeat.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: tracks four PS/2 game keys as held levels and press pulses, and queues their events in a FIFO (optional KEY_REPEAT_EN)
module ps2_key_tracker #(
  parameter logic [8:0] KEY0_CODE  = 9'h029,
  parameter logic [8:0] KEY1_CODE  = 9'h175,
  parameter logic [8:0] KEY2_CODE  = 9'h05A,
  parameter logic [8:0] KEY3_CODE  = 9'h076,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_data,
  input  logic       key_ready,
  output logic [3:0] key_held,
  output logic [3:0] key_press,
  output logic       evt_valid,
  output logic [2:0] evt_data,
  input  logic       evt_pop,
  output logic       evt_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [35:0] CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};
`ifdef KEY_REPEAT_EN
  localparam logic REPEAT = 1'b1;
`else
  localparam logic REPEAT = 1'b0;
`endif
  logic          hit, brk, fire, full, pop_ok, wr_ok;
  logic [1:0]    idx;
  logic [3:0]    held_q, held_d, press_q, press_d;
  logic          push_q, push_d, ovf_q, ovf_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [2:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  // match the strobed code against the key table; lowest index wins on duplicates
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 3; i >= 0; i--)
      if ({key_data[9], key_data[7:0]} == CODES[i*9 +: 9]) begin
        hit = key_ready;
        idx = 2'(i);
      end
  end
  // per-key up/down state; an event fires on a fresh make, a repeat (if enabled) or a real break
  always_comb begin
    brk     = key_data[8];
    fire    = hit && (brk ? held_q[idx] : (!held_q[idx] || REPEAT));
    held_d  = held_q;
    if (hit) held_d[idx] = !brk;
    press_d = (fire && !brk) ? 4'b0001 << idx : 4'b0000;
    push_d  = fire;
    pend_d  = {brk, idx};
  end
  // FIFO bookkeeping: full+pop lets the push through, empty ignores the pop
  always_comb begin
    full   = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop_ok = evt_pop && cnt_q != '0;
    wr_ok  = push_q && (!full || pop_ok);
    mem_d  = mem_q;
    if (wr_ok) mem_d[wr_q] = pend_q;
    wr_d   = wr_q + AW'(wr_ok);
    rd_d   = rd_q + AW'(pop_ok);
    cnt_d  = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(pop_ok);
    ovf_d  = ovf_q || (push_q && !wr_ok);
  end
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      press_q <= '0;
      push_q  <= 1'b0;
      pend_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      held_q  <= held_d;
      press_q <= press_d;
      push_q  <= push_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  // event storage needs no reset; the count masks stale entries
  always_ff @(posedge clk) mem_q <= mem_d;
  assign key_held  = held_q;
  assign key_press = press_q;
  assign evt_valid = cnt_q != '0;
  assign evt_data  = evt_valid ? mem_q[rd_q] : 3'b000;
  assign evt_ovf   = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed vector table plus randomized run against a queue-based model
module tb_ps2_key_tracker;
  localparam int DEPTH = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b0, key_ready = 1'b0, evt_pop = 1'b0;
  logic [9:0] key_data = '0;
  logic [3:0] key_held, key_press;
  logic       evt_valid, evt_ovf;
  logic [2:0] evt_data;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [9:0] d;
    logic       rdy, pop, rs;
    logic [3:0] held, press;
    logic       valid;
    logic [2:0] data;
    logic       ovf;
  } vec_t;
  vec_t tbl[$];

  logic [8:0] codes [4] = '{9'h029, 9'h175, 9'h05A, 9'h076};
  bit [3:0] m_held, m_press;
  bit       m_pend, m_ovf;
  bit [2:0] m_pend_d;
  bit [2:0] m_q[$];

  ps2_key_tracker dut (
    .clk(clk), .rst(rst), .key_data(key_data), .key_ready(key_ready),
    .key_held(key_held), .key_press(key_press), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_pop(evt_pop), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic [9:0] d, input logic rdy, input logic pop, input logic rs);
    int  k, sz;
    bit  popped;
    if (rs) begin
      m_held = '0; m_press = '0; m_pend = 0; m_ovf = 0; m_q.delete();
      return;
    end
    sz = m_q.size();
    popped = pop && sz > 0;
    if (popped) void'(m_q.pop_front());
    if (m_pend) begin
      if (sz == DEPTH && !popped) m_ovf = 1;
      else m_q.push_back(m_pend_d);
    end
    m_pend = 0;
    m_press = '0;
    k = -1;
    for (int i = 0; i < 4; i++) if (k < 0 && {d[9], d[7:0]} == codes[i]) k = i;
    if (rdy && k >= 0) begin
      if (!d[8]) begin
        if (!m_held[k] || REP) begin
          m_press[k] = 1; m_pend = 1; m_pend_d = {1'b0, 2'(k)};
        end
        m_held[k] = 1;
      end else if (m_held[k]) begin
        m_held[k] = 0; m_pend = 1; m_pend_d = {1'b1, 2'(k)};
      end
    end
  endtask

  task automatic drive(input logic [9:0] d, input logic rdy, input logic pop, input logic rs);
    key_data = d; key_ready = rdy; evt_pop = pop; rst = rs;
    @(posedge clk);
    model_step(d, rdy, pop, rs);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " held"}, 8'(key_held), 8'(m_held));
    chk({nm, " press"}, 8'(key_press), 8'(m_press));
    chk({nm, " valid"}, 8'(evt_valid), 8'(m_q.size() != 0));
    chk({nm, " data"}, 8'(evt_data), 8'(m_q.size() != 0 ? m_q[0] : 3'b000));
    chk({nm, " ovf"}, 8'(evt_ovf), 8'(m_ovf));
  endtask

  task automatic add(input logic [9:0] d, input logic rdy, input logic pop, input logic rs,
                     input logic [3:0] h, input logic [3:0] p, input logic v, input logic [2:0] dt, input logic o);
    vec_t e;
    e.d = d; e.rdy = rdy; e.pop = pop; e.rs = rs;
    e.held = h; e.press = p; e.valid = v; e.data = dt; e.ovf = o;
    tbl.push_back(e);
  endtask

  initial begin
    bit [8:0] c;
    int pk;
    //  data    rdy pop rst  held     press    v  data    ovf
    add(10'h000, 0, 0, 1, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h029, 1, 0, 0, 4'b0001, 4'b0001, 0, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b0001, 4'b0000, 1, 3'b000, 0);
    add(10'h029, 1, 0, 0, 4'b0001, 4'b0000, 1, 3'b000, 0);
    add(10'h029, 1, 0, 0, 4'b0001, 4'b0000, 1, 3'b000, 0);
    add(10'h029, 1, 0, 0, 4'b0001, 4'b0000, 1, 3'b000, 0);
    add(10'h129, 1, 0, 0, 4'b0000, 4'b0000, 1, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b0000, 4'b0000, 1, 3'b000, 0);
    add(10'h000, 0, 1, 0, 4'b0000, 4'b0000, 1, 3'b100, 0);
    add(10'h000, 0, 1, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h275, 1, 0, 0, 4'b0010, 4'b0010, 0, 3'b000, 0);
    add(10'h075, 1, 0, 0, 4'b0010, 4'b0000, 1, 3'b001, 0);
    add(10'h000, 0, 0, 0, 4'b0010, 4'b0000, 1, 3'b001, 0);
    add(10'h000, 0, 1, 0, 4'b0010, 4'b0000, 0, 3'b000, 0);
    add(10'h375, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b0000, 4'b0000, 1, 3'b101, 0);
    add(10'h000, 0, 1, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h15A, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h01C, 1, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h000, 0, 1, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h029, 1, 0, 0, 4'b0001, 4'b0001, 0, 3'b000, 0);
    add(10'h275, 1, 0, 0, 4'b0011, 4'b0010, 1, 3'b000, 0);
    add(10'h05A, 1, 0, 0, 4'b0111, 4'b0100, 1, 3'b000, 0);
    add(10'h076, 1, 0, 0, 4'b1111, 4'b1000, 1, 3'b000, 0);
    add(10'h129, 1, 0, 0, 4'b1110, 4'b0000, 1, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b1110, 4'b0000, 1, 3'b000, 1);
    add(10'h029, 1, 0, 0, 4'b1111, 4'b0001, 1, 3'b000, 1);
    add(10'h000, 0, 1, 0, 4'b1111, 4'b0000, 1, 3'b001, 1);
    add(10'h000, 0, 1, 0, 4'b1111, 4'b0000, 1, 3'b010, 1);
    add(10'h000, 0, 1, 0, 4'b1111, 4'b0000, 1, 3'b011, 1);
    add(10'h000, 0, 1, 0, 4'b1111, 4'b0000, 1, 3'b000, 1);
    add(10'h000, 0, 1, 0, 4'b1111, 4'b0000, 0, 3'b000, 1);
    add(10'h129, 1, 0, 0, 4'b1110, 4'b0000, 0, 3'b000, 1);
    add(10'h375, 1, 0, 0, 4'b1100, 4'b0000, 1, 3'b100, 1);
    add(10'h000, 0, 0, 0, 4'b1100, 4'b0000, 1, 3'b100, 1);
    add(10'h000, 0, 0, 1, 4'b0000, 4'b0000, 0, 3'b000, 0);
    add(10'h000, 0, 0, 0, 4'b0000, 4'b0000, 0, 3'b000, 0);
`ifndef KEY_REPEAT_EN
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].d, tbl[r].rdy, tbl[r].pop, tbl[r].rs);
      chk($sformatf("row%0d held", r), 8'(key_held), 8'(tbl[r].held));
      chk($sformatf("row%0d press", r), 8'(key_press), 8'(tbl[r].press));
      chk($sformatf("row%0d valid", r), 8'(evt_valid), 8'(tbl[r].valid));
      chk($sformatf("row%0d data", r), 8'(evt_data), 8'(tbl[r].data));
      chk($sformatf("row%0d ovf", r), 8'(evt_ovf), 8'(tbl[r].ovf));
    end
`else
    drive(10'h000, 0, 0, 1);
    chk("rep reset held", 8'(key_held), 8'h0);
    drive(10'h05A, 1, 0, 0);
    chk("rep make press", 8'(key_press), 8'h4);
    drive(10'h05A, 1, 0, 0);
    chk("rep repeat1 press", 8'(key_press), 8'h4);
    chk("rep repeat1 held", 8'(key_held), 8'h4);
    drive(10'h000, 0, 0, 0);
    chk("rep idle press", 8'(key_press), 8'h0);
    chk("rep idle data", 8'(evt_data), 8'h2);
    drive(10'h05A, 1, 0, 0);
    chk("rep repeat2 press", 8'(key_press), 8'h4);
`endif
    drive(10'h000, 0, 0, 1);
    chk_model("rand reset");
    for (int i = 0; i < 4000; i++) begin
      pk = $urandom_range(0, 6);
      c = pk < 4 ? codes[pk] : pk == 4 ? 9'h075 : pk == 5 ? 9'h029 ^ 9'h100 : 9'($urandom);
      drive({c[8], 1'($urandom_range(0, 1)), c[7:0]}, 1'($urandom_range(0, 1)),
            ((i / 300) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 299) == 0);
      chk_model($sformatf("rand%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
